// File: rtl/xy_plot_writer.sv
`default_nettype none
// ============================================================================
// Module      : xy_plot_writer
// Description : Turns a 14-bit (X, Y) sample stream into monochrome pixel
//               writes. Kept samples are scaled to screen coordinates
//               (Y inverted), converted to a linear framebuffer address and
//               queued in a FIFO that drains through a valid/ready write
//               port. A clear sweep blanks the screen after reset and on
//               request.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_plot_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [13:0] x_in,
  input  logic [13:0] y_in,
  input  logic [2:0]  decim,
  input  logic        clear_req,
  output logic [18:0] fb_addr,
  output logic        fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int          XW      = $clog2(SCREEN_W);
  localparam int          YW      = $clog2(SCREEN_H);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [18:0] C_LAST  = 19'(SCREEN_W * SCREEN_H - 1);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLOT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [18:0]     clr_cnt_q, clr_cnt_d;
  logic [2:0]      dec_cnt_q, dec_cnt_d;
  logic            s1_valid_q, s1_valid_d;
  logic [XW-1:0]   sx_q, sx_d;
  logic [YW-1:0]   sy_q, sy_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [18:0]     fifo_mem_q [FIFO_DEPTH];

  logic [XW-1:0]   w_sx;
  logic [YW-1:0]   w_sy;
  logic [18:0]     w_addr;
  logic [18:0]     w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_push;

  // Scaling uses a 33-bit product so full-scale samples never wrap; the
  // shift by 14 truncates toward zero, keeping results inside the screen.
  assign w_sx   = XW'(({19'd0, x_in} * 33'(SCREEN_W)) >> 14);
  assign w_sy   = YW'(SCREEN_H - 1) - YW'(({19'd0, y_in} * 33'(SCREEN_H)) >> 14);
  assign w_addr = 19'(sy_q) * 19'(SCREEN_W) + 19'(sx_q);

  // Fullness comes from registered pointers only, so a pop on the same edge
  // never makes room for the incoming entry.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = ((wr_ptr_q - rd_ptr_q) == C_DEPTH);
  assign w_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  assign busy     = (state_q != ST_PLOT);
  assign overflow = overflow_q;

  // Next-state, pipeline, FIFO pointer and write-port logic.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    s1_valid_d = 1'b0;
    sx_d       = sx_q;
    sy_d       = sy_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    w_push     = 1'b0;
    fb_we      = 1'b0;
    fb_data    = 1'b0;
    fb_addr    = 19'd0;

    case (state_q)
      ST_INIT: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = 19'd0;
      end

      ST_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_cnt_q;
        if (clear_req) begin
          clr_cnt_d = 19'd0;
        end else if (fb_ready) begin
          if (clr_cnt_q == C_LAST) begin
            state_d   = ST_PLOT;
            clr_cnt_d = 19'd0;
          end else begin
            clr_cnt_d = clr_cnt_q + 19'd1;
          end
        end
      end

      ST_PLOT: begin
        fb_we   = !w_empty;
        fb_data = 1'b1;
        fb_addr = w_head;
        if (clear_req) begin
          // Flush queue and pipeline; s1_valid_d is already cleared.
          state_d    = ST_CLEAR;
          clr_cnt_d  = 19'd0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
        end else begin
          if (!w_empty && fb_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          if (s1_valid_q) begin
            if (w_full) begin
              overflow_d = 1'b1;
            end else begin
              w_push   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
          if (sample_valid) begin
            s1_valid_d = (dec_cnt_q == 3'd0);
            dec_cnt_d  = (dec_cnt_q >= decim) ? 3'd0 : dec_cnt_q + 3'd1;
            sx_d       = w_sx;
            sy_d       = w_sy;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= 19'd0;
      dec_cnt_q  <= 3'd0;
      s1_valid_q <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      s1_valid_q <= s1_valid_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= w_addr;
    end
  end

endmodule
`default_nettype wire
